// File: rtl/imm_encoder_loader.sv
// Encodes decoded instruction fields into 16-bit words and
// streams them into instruction memory, halting on the first illegal one.
module imm_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [15:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] remaining;

   logic        c_jal, c_ri, c_bs, c_r, c_lui, c_rsv;
   logic        imm4_ok, imm8_ok;
   logic        legal;
   logic [15:0] enc;
   logic        accept;

   assign busy     = (state == S_RUN);
   assign in_ready = busy && (remaining != '0);
   assign accept   = in_valid && in_ready;

   // Field-layout classes; exactly one is set for any opcode.
   assign c_jal = (in_op == 4'h0);
   assign c_ri  = (in_op == 4'h1) || (in_op[3:1] == 3'b010)
               || (in_op[3:1] == 3'b110);
   assign c_bs  = (in_op[3:1] == 3'b001) || (in_op[3:1] == 3'b011);
   assign c_r   = (in_op[3:2] == 2'b10);
   assign c_lui = (in_op == 4'he);
   assign c_rsv = (in_op == 4'hf);

   // An immediate fits when its upper bits are a pure sign extension.
   assign imm4_ok = (&in_imm[15:3]) || ~(|in_imm[15:3]);
   assign imm8_ok = (&in_imm[15:7]) || ~(|in_imm[15:7]);

   always_comb begin
      enc   = '0;
      legal = 1'b0;
      unique case (1'b1)
         c_jal: begin
            enc   = {in_imm[7:0], in_rd, in_op};
            legal = imm8_ok;
         end
         c_ri: begin
            enc   = {in_imm[3:0], in_rs1, in_rd, in_op};
            legal = imm4_ok;
         end
         c_bs: begin
            enc   = {in_rs2, in_rs1, in_imm[3:0], in_op};
            legal = imm4_ok;
         end
         c_r: begin
            enc   = {in_rs2, in_rs1, in_rd, in_op};
            legal = 1'b1;
         end
         c_lui: begin
            enc   = {in_imm[15:8], in_rd, in_op};
            legal = (in_imm[7:0] == 8'h00);
         end
         c_rsv: begin
            enc   = {12'h000, in_op};
            legal = 1'b0;
         end
         default: begin
            enc   = '0;
            legal = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_ERR: begin
            if (start)
               state_nx = (count == '0) ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (accept && !legal)      state_nx = S_ERR;
            else if (remaining == '0)  state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base      <= '0;
         idx       <= '0;
         remaining <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_idx   <= '0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         unique case (state)
            S_IDLE, S_ERR: begin
               if (start) begin
                  base      <= base_addr;
                  remaining <= count;
                  idx       <= '0;
                  err       <= 1'b0;
                  err_idx   <= '0;
                  done      <= (count == '0);
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (legal) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= base + idx;
                     mem_wdata <= enc;
                     idx       <= idx + ADDR_W'(1);
                     remaining <= remaining - ADDR_W'(1);
                  end else begin
                     err     <= 1'b1;
                     err_idx <= idx;
                  end
               end else if (remaining == '0) begin
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Directed bench for imm_encoder_loader: a table of single-instruction
// loads plus hand-written multi-cycle sequences.
module tb_imm_encoder_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] count = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_op = '0;
   logic [3:0]        in_rd = '0;
   logic [3:0]        in_rs1 = '0;
   logic [3:0]        in_rs2 = '0;
   logic [15:0]       in_imm = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] err_idx;

   int checks = 0;
   int failures = 0;

   imm_encoder_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_idx   (err_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [15:0] imm;
      logic        ok;
      logic [15:0] word;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b,
                           input logic [ADDR_W-1:0] c);
      start     = 1'b1;
      base_addr = b;
      count     = c;
      tick();
      start     = 1'b0;
   endtask

   task automatic set_fields(input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [15:0] imm);
      in_op  = op;
      in_rd  = rd;
      in_rs1 = rs1;
      in_rs2 = rs2;
      in_imm = imm;
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [15:0] imm);
      set_fields(op, rd, rs1, rs2, imm);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_write(input string name, input logic [ADDR_W-1:0] a,
                            input logic [15:0] w);
      chk({name, ".we"}, mem_we, 1);
      chk({name, ".addr"}, mem_addr, a);
      chk({name, ".wdata"}, mem_wdata, w);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".in_ready"}, in_ready, 0);
      chk({name, ".mem_we"}, mem_we, 0);
      chk({name, ".mem_addr"}, mem_addr, 0);
      chk({name, ".mem_wdata"}, mem_wdata, 0);
      chk({name, ".busy"}, busy, 0);
      chk({name, ".done"}, done, 0);
      chk({name, ".err"}, err, 0);
      chk({name, ".err_idx"}, err_idx, 0);
   endtask

   initial begin
      int n_done;
      int n_we;
      int i;

      tbl[0]  = '{4'h1, 4'h2, 4'h7, 4'h0, 16'h0007, 1'b1, 16'h7721};
      tbl[1]  = '{4'h3, 4'h0, 4'h3, 4'h4, 16'hFFFF, 1'b1, 16'h43F3};
      tbl[2]  = '{4'h4, 4'h9, 4'hA, 4'h0, 16'hFFF8, 1'b1, 16'h8A94};
      tbl[3]  = '{4'h6, 4'h0, 4'h1, 4'hF, 16'h0000, 1'b1, 16'hF106};
      tbl[4]  = '{4'hD, 4'hF, 4'h0, 4'h0, 16'h0001, 1'b1, 16'h10FD};
      tbl[5]  = '{4'h0, 4'h0, 4'h0, 4'h0, 16'h007F, 1'b1, 16'h7F00};
      tbl[6]  = '{4'h0, 4'h1, 4'h0, 4'h0, 16'hFF80, 1'b1, 16'h8010};
      tbl[7]  = '{4'h0, 4'h1, 4'h0, 4'h0, 16'h0080, 1'b0, 16'h0000};
      tbl[8]  = '{4'hB, 4'h4, 4'h5, 4'h6, 16'h7FFF, 1'b1, 16'h654B};
      tbl[9]  = '{4'hE, 4'h7, 4'h0, 4'h0, 16'hFF00, 1'b1, 16'hFF7E};
      tbl[10] = '{4'hE, 4'h7, 4'h0, 4'h0, 16'h0001, 1'b0, 16'h0000};
      tbl[11] = '{4'hF, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b0, 16'h0000};
      tbl[12] = '{4'h5, 4'h1, 4'h2, 4'h0, 16'hFFF7, 1'b0, 16'h0000};
      tbl[13] = '{4'hC, 4'h1, 4'h1, 4'h0, 16'h0007, 1'b1, 16'h711C};

      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      #10 rst_n = 1'b1;
      tick();

      // single addi load
      do_start(8'h10, 8'd1);
      chk("s1.busy", busy, 1);
      chk("s1.in_ready", in_ready, 1);
      send(4'hC, 4'h1, 4'h2, 4'h0, 16'hFFFD);
      chk_write("s1", 8'h10, 16'hD21C);
      chk("s1.ready_drop", in_ready, 0);
      chk("s1.no_done_yet", done, 0);
      tick();
      chk("s1.done", done, 1);
      chk("s1.busy_low", busy, 0);
      chk("s1.we_low", mem_we, 0);
      chk("s1.wdata_hold", mem_wdata, 16'hD21C);
      tick();
      chk("s1.done_pulse", done, 0);

      // four back-to-back instructions
      do_start(8'h10, 8'd4);
      in_valid = 1'b1;
      set_fields(4'h0, 4'h3, 4'h0, 4'h0, 16'hFFFE);
      tick();
      chk_write("s2.jal", 8'h10, 16'hFE30);
      set_fields(4'hE, 4'h5, 4'h0, 4'h0, 16'h1200);
      tick();
      chk_write("s2.lui", 8'h11, 16'h125E);
      set_fields(4'h7, 4'h0, 4'h4, 4'h6, 16'h0007);
      tick();
      chk_write("s2.sw", 8'h12, 16'h6477);
      set_fields(4'h2, 4'h0, 4'h1, 4'h2, 16'hFFF8);
      tick();
      chk_write("s2.beq", 8'h13, 16'h2182);
      chk("s2.ready_drop", in_ready, 0);
      n_done = 0;
      n_we = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done) n_done++;
         if (mem_we) n_we++;
      end
      in_valid = 1'b0;
      chk("s2.done_count", n_done, 1);
      chk("s2.extra_writes", n_we, 0);

      // illegal immediate on the second instruction
      do_start(8'h10, 8'd3);
      send(4'hC, 4'h1, 4'h2, 4'h0, 16'hFFFD);
      chk_write("s3.first", 8'h10, 16'hD21C);
      send(4'hC, 4'h1, 4'h2, 4'h0, 16'h0008);
      chk("s3.no_write", mem_we, 0);
      chk("s3.err", err, 1);
      chk("s3.err_idx", err_idx, 1);
      chk("s3.busy", busy, 0);
      chk("s3.in_ready", in_ready, 0);
      in_valid = 1'b1;
      set_fields(4'hC, 4'h1, 4'h2, 4'h0, 16'h0001);
      n_done = 0;
      n_we = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done) n_done++;
         if (mem_we) n_we++;
      end
      in_valid = 1'b0;
      chk("s3.no_done", n_done, 0);
      chk("s3.no_more_writes", n_we, 0);
      chk("s3.err_sticky", err, 1);
      // count=0 start from ERR clears err and pulses done
      do_start(8'h20, 8'd0);
      chk("s3.err_clear", err, 0);
      chk("s3.err_idx_clear", err_idx, 0);
      chk("s3.zero_done", done, 1);
      chk("s3.zero_busy", busy, 0);
      chk("s3.zero_we", mem_we, 0);
      tick();
      chk("s3.zero_done_pulse", done, 0);

      // address wrap
      do_start(8'hFE, 8'd3);
      in_valid = 1'b1;
      set_fields(4'h8, 4'h1, 4'h2, 4'h3, 16'h0000);
      tick();
      chk_write("s4.a", 8'hFE, 16'h3218);
      tick();
      chk_write("s4.b", 8'hFF, 16'h3218);
      tick();
      chk_write("s4.c", 8'h00, 16'h3218);
      in_valid = 1'b0;
      tick();
      chk("s4.done", done, 1);

      // gapped valid and a start pulse while busy
      do_start(8'h40, 8'd3);
      start = 1'b1;
      base_addr = 8'h80;
      count = 8'd5;
      send(4'h0, 4'h1, 4'h0, 4'h0, 16'h0005);
      start = 1'b0;
      chk_write("s5.a", 8'h40, 16'h0510);
      tick();
      chk("s5.gap_we", mem_we, 0);
      chk("s5.gap_ready", in_ready, 1);
      send(4'h0, 4'h2, 4'h0, 4'h0, 16'h0005);
      chk_write("s5.b", 8'h41, 16'h0520);
      send(4'h0, 4'h3, 4'h0, 4'h0, 16'h0005);
      chk_write("s5.c", 8'h42, 16'h0530);
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done) n_done++;
      end
      chk("s5.done_count", n_done, 1);

      // lui with low byte set
      do_start(8'h60, 8'd2);
      send(4'hE, 4'h1, 4'h0, 4'h0, 16'h1234);
      chk("s6.no_write", mem_we, 0);
      chk("s6.err", err, 1);
      chk("s6.err_idx", err_idx, 0);

      // in_valid outside RUN
      in_valid = 1'b1;
      set_fields(4'h8, 4'h1, 4'h2, 4'h3, 16'h0000);
      tick();
      tick();
      in_valid = 1'b0;
      chk("s7.idle_we", mem_we, 0);
      chk("s7.idle_ready", in_ready, 0);

      // table of single-instruction loads
      for (i = 0; i < 14; i++) begin
         do_start(8'h30 + 8'(i), 8'd1);
         send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
         if (tbl[i].ok) begin
            chk_write($sformatf("tbl%0d", i), 8'h30 + 8'(i), tbl[i].word);
            chk($sformatf("tbl%0d.err", i), err, 0);
            tick();
            chk($sformatf("tbl%0d.done", i), done, 1);
         end else begin
            chk($sformatf("tbl%0d.we", i), mem_we, 0);
            chk($sformatf("tbl%0d.err", i), err, 1);
            chk($sformatf("tbl%0d.err_idx", i), err_idx, 0);
            tick();
            chk($sformatf("tbl%0d.nodone", i), done, 0);
         end
      end

      // reset in the middle of a load
      do_start(8'h50, 8'd3);
      send(4'h8, 4'h1, 4'h2, 4'h3, 16'h0000);
      chk("s8.pre_we", mem_we, 1);
      in_valid = 1'b1;
      set_fields(4'h8, 4'h4, 4'h5, 4'h6, 16'h0000);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("s8.async");
      tick();
      chk("s8.dropped_we", mem_we, 0);
      chk("s8.state_idle", busy, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("s8.post_ready", in_ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
